// File: rtl/grid_arbiter_if.sv
// Requester-side bus of the grid RAM arbiter: packed per-requester request fields
// plus grant, read-return and error strobes.
interface grid_arbiter_if #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        we;
   logic [NREQ*ADDR_W-1:0] addr;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;
   logic                   err;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/grid_arbiter.sv
// Round-robin arbiter serialising requester accesses to the single-port placement grid RAM.
// Define GRID_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module grid_arbiter #(
   parameter int NREQ   = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   grid_arbiter_if.slave     bus,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  last_gnt, cur_idx, sel_idx;
   logic              sel_found, cur_we, cur_inr;
   logic              sel_we, sel_inr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [NREQ-1:0]   gnt_q, gnt_nxt, rvalid_q, rvalid_nxt;
   logic              err_q, err_nxt, re_q, re_nxt, we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;

   // Winner selection; round-robin search starts just after the last granted requester.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
`ifdef GRID_ARB_FIXED_PRIO_EN
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            sel_idx   = IDX_W'(i);
            sel_found = 1'b1;
         end
      end
`else
      for (int i = 1; i <= NREQ; i++) begin
         if (!sel_found && bus.req[(int'(last_gnt) + i) % NREQ]) begin
            sel_idx   = IDX_W'((int'(last_gnt) + i) % NREQ);
            sel_found = 1'b1;
         end
      end
`endif
   end

   // Signed range check: negative addresses have the top bit set.
   always_comb begin
      sel_we    = bus.we[sel_idx];
      sel_addr  = bus.addr[int'(sel_idx)*ADDR_W +: ADDR_W];
      sel_wdata = bus.wdata[int'(sel_idx)*DATA_W +: DATA_W];
      sel_inr   = !sel_addr[ADDR_W-1] && (sel_addr < ADDR_W'(DEPTH));
   end

   always_comb begin
      state_nxt  = state;
      gnt_nxt    = '0;
      rvalid_nxt = '0;
      err_nxt    = 1'b0;
      re_nxt     = 1'b0;
      we_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt = ISSUE;
               gnt_nxt   = NREQ'(1) << sel_idx;
               err_nxt   = !sel_inr;
               re_nxt    = sel_inr && !sel_we;
               we_nxt    = sel_inr && sel_we;
            end
         end
         ISSUE: begin
            if (cur_we) begin
               state_nxt = IDLE;
            end else begin
               state_nxt  = RDWAIT;
               rvalid_nxt = NREQ'(1) << cur_idx;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are registered so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last_gnt <= IDX_W'(NREQ - 1);
         cur_idx  <= '0;
         cur_we   <= 1'b0;
         cur_inr  <= 1'b0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         err_q    <= 1'b0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
      end else begin
         state    <= state_nxt;
         gnt_q    <= gnt_nxt;
         rvalid_q <= rvalid_nxt;
         err_q    <= err_nxt;
         re_q     <= re_nxt;
         we_q     <= we_nxt;
         if (state == IDLE && sel_found) begin
            last_gnt <= sel_idx;
            cur_idx  <= sel_idx;
            cur_we   <= sel_we;
            cur_inr  <= sel_inr;
            addr_q   <= sel_addr;
            din_q    <= sel_wdata;
         end
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.rdata  = (|rvalid_q) ? (cur_inr ? mem_dout : '1) : '0;
   assign mem_re     = re_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter with a small registered-read grid RAM model.
module tb_grid_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_re, mem_we;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [31:0] ram [16];
   int          checks = 0;
   int          errors = 0;

   grid_arbiter_if #(.NREQ(2), .DATA_W(32), .ADDR_W(32)) bus ();

   grid_arbiter #(.NREQ(2), .DATA_W(32), .ADDR_W(32), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Grid RAM: write on mem_we, registered read on mem_re.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[3:0]] <= mem_din;
      if (mem_re) mem_dout <= ram[mem_addr[3:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req = 2'b00; bus.we = 2'b00; bus.addr = '0; bus.wdata = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
      checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_re, mem_we}); end
      checks++; if ({mem_addr, mem_din} !== 64'h0) begin errors++; $display("FAIL reset_memaddr_din: got %h expected 0", {mem_addr, mem_din}); end
   endtask

   task automatic test_single_write();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr[31:0] = 32'd5; bus.wdata[31:0] = 32'd7;
      tick();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", bus.gnt); end
      checks++; if ({mem_we, mem_re} !== 2'b10) begin errors++; $display("FAIL wr_strobes: got %b expected 10", {mem_we, mem_re}); end
      checks++; if (mem_addr !== 32'd5 || mem_din !== 32'd7) begin errors++; $display("FAIL wr_addr_din: got %0d/%0d expected 5/7", mem_addr, mem_din); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", bus.err); end
      bus.req = 2'b00;
      tick();
      checks++; if (bus.gnt !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL wr_pulse_len: got gnt %b we %b expected 00 0", bus.gnt, mem_we); end
      bus.req = 2'b01; bus.we = 2'b00;
      tick();
      checks++; if (bus.gnt !== 2'b01 || mem_re !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b re %b expected 01 1", bus.gnt, mem_re); end
      bus.req = 2'b00;
      tick();
      checks++; if (bus.rvalid !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b expected 01", bus.rvalid); end
      checks++; if (bus.rdata !== 32'd7) begin errors++; $display("FAIL rd_rdata: got %0d expected 7", bus.rdata); end
      tick();
      checks++; if (bus.rvalid !== 2'b00 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rd_idle: got %b %h expected 00 0", bus.rvalid, bus.rdata); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_gnt [3];
`ifdef GRID_ARB_FIXED_PRIO_EN
      exp_gnt = '{2'b01, 2'b01, 2'b01};
`else
      exp_gnt = '{2'b01, 2'b10, 2'b01};
`endif
      // Requester 1 seeds addr 3 with 9, leaving it as last grantee.
      bus.req = 2'b10; bus.we = 2'b10; bus.addr[63:32] = 32'd3; bus.wdata[63:32] = 32'd9;
      tick();
      checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL seed_gnt: got %b expected 10", bus.gnt); end
      bus.req = 2'b00;
      tick();
      bus.req = 2'b11; bus.we = 2'b00; bus.addr[31:0] = 32'd3; bus.addr[63:32] = 32'd3;
      for (int t = 0; t < 3; t++) begin
         tick();
         checks++; if (bus.gnt !== exp_gnt[t]) begin errors++; $display("FAIL cont_gnt%0d: got %b expected %b", t, bus.gnt, exp_gnt[t]); end
         tick();
         checks++; if (bus.rvalid !== exp_gnt[t]) begin errors++; $display("FAIL cont_rvalid%0d: got %b expected %b", t, bus.rvalid, exp_gnt[t]); end
         checks++; if (bus.rdata !== 32'd9) begin errors++; $display("FAIL cont_rdata%0d: got %0d expected 9", t, bus.rdata); end
         if (t == 2) bus.req = 2'b00;
         tick();
      end
   endtask

   task automatic test_out_of_range();
      bus.req = 2'b10; bus.we = 2'b00; bus.addr[63:32] = 32'd16;
      tick();
      checks++; if (bus.gnt !== 2'b10 || bus.err !== 1'b1) begin errors++; $display("FAIL oor_rd_gnt_err: got %b %b expected 10 1", bus.gnt, bus.err); end
      checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL oor_rd_re: got %b expected 0", mem_re); end
      bus.req = 2'b00;
      tick();
      checks++; if (bus.rvalid !== 2'b10 || bus.rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL oor_rd_data: got %b %h expected 10 ffffffff", bus.rvalid, bus.rdata); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", bus.err); end
      tick();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr[31:0] = 32'hFFFFFFFF; bus.wdata[31:0] = 32'd42;
      tick();
      checks++; if (bus.gnt !== 2'b01 || bus.err !== 1'b1) begin errors++; $display("FAIL oor_wr_gnt_err: got %b %b expected 01 1", bus.gnt, bus.err); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL oor_wr_we: got %b expected 0", mem_we); end
      bus.req = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr[31:0] = 32'd3;
      tick();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rstmid_gnt: got %b expected 01", bus.gnt); end
      bus.req = 2'b00; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.rvalid !== 2'b00 || bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_abort: got rvalid %b gnt %b expected 00 00", bus.rvalid, bus.gnt); end
      checks++; if ({mem_re, mem_we, bus.err} !== 3'b000 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got %b %h expected 000 0", {mem_re, mem_we, bus.err}, bus.rdata); end
      bus.req = 2'b11; bus.addr[63:32] = 32'd3;
      tick();
      checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rstmid_rr_restart: got %b expected 01", bus.gnt); end
      bus.req = 2'b00;
      tick();
      checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== 32'd9) begin errors++; $display("FAIL rstmid_read: got %b %0d expected 01 9", bus.rvalid, bus.rdata); end
      tick();
   endtask

   task automatic test_stale_fields();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr[31:0] = 32'd3;
      tick();
      checks++; if (mem_addr !== 32'd3 || mem_re !== 1'b1) begin errors++; $display("FAIL stale_issue: got %0d %b expected 3 1", mem_addr, mem_re); end
      bus.req = 2'b00; bus.addr[31:0] = 32'd5; bus.we = 2'b01;
      tick();
      checks++; if (bus.rvalid !== 2'b01 || bus.rdata !== 32'd9) begin errors++; $display("FAIL stale_rdata: got %b %0d expected 01 9", bus.rvalid, bus.rdata); end
      checks++; if (mem_addr !== 32'd3 || mem_we !== 1'b0) begin errors++; $display("FAIL stale_memaddr: got %0d %b expected 3 0", mem_addr, mem_we); end
      bus.we = 2'b00;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_single_write();
      test_contention();
      test_out_of_range();
      test_reset_mid();
      test_stale_fields();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
